// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter stage that sits directly after the branch-decision logic.
// It holds the PC, works out the next PC (sequential, PC-relative branch or
// absolute branch), and owns run / halt / single-step control. The commit
// output qualifies every architectural write in the single-cycle datapath.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst_n          synchronous, active-low reset
//   take_branch    branch-taken decision for the current instruction
//   branch_abs     1 = absolute target, 0 = PC-relative offset
//   branch_offset  branch field (signed when relative, unsigned when absolute)
//   run            level request for free-running execution
//   step           synchronised, debounced button; rising edge = one instruction
//   halt_req       decoded HALT instruction at the current PC
//   pc             current instruction address (registered)
//   pc_plus1       pc + 1 modulo 2^PC_WIDTH (combinational)
//   commit         current instruction retires this cycle
//   running        free-running state indicator
//   retired        count of committed instructions (wraps)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int PC_WIDTH     = 8,
    parameter int OFFSET_WIDTH = 8,
    parameter int RESET_VECTOR = 0,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    take_branch,
    input  logic                    branch_abs,
    input  logic [OFFSET_WIDTH-1:0] branch_offset,
    input  logic                    run,
    input  logic                    step,
    input  logic                    halt_req,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [PC_WIDTH-1:0]     pc_plus1,
    output logic                    commit,
    output logic                    running,
    output logic [COUNT_WIDTH-1:0]  retired
);

    localparam logic [1:0] HALTED   = 2'b00;
    localparam logic [1:0] RUNNING  = 2'b01;
    localparam logic [1:0] STEPPING = 2'b10;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic                step_q;
    logic                step_rise;
    logic [PC_WIDTH-1:0] offset_sx;
    logic [PC_WIDTH-1:0] offset_zx;
    logic [PC_WIDTH-1:0] next_pc;

    // Fit the instruction's branch field to the PC width: truncate when the
    // field is wider, otherwise sign-extend (relative) or zero-extend (absolute).
    generate
        if (OFFSET_WIDTH >= PC_WIDTH) begin : g_trunc
            assign offset_sx = branch_offset[PC_WIDTH-1:0];
            assign offset_zx = branch_offset[PC_WIDTH-1:0];
        end else begin : g_ext
            assign offset_sx = {{(PC_WIDTH-OFFSET_WIDTH){branch_offset[OFFSET_WIDTH-1]}},
                                branch_offset};
            assign offset_zx = {{(PC_WIDTH-OFFSET_WIDTH){1'b0}}, branch_offset};
        end
    endgenerate

    assign pc_plus1  = pc + PC_WIDTH'(1);
    assign step_rise = step & ~step_q;

    // Commit is decoded from state alone so the write-enable never glitches
    // on input changes; the unused encoding never commits.
    assign commit  = (state == RUNNING) | (state == STEPPING);
    assign running = (state == RUNNING);

    // Wrap-around in either direction is intentional and silent.
    always_comb begin
        next_pc = pc_plus1;
        if (take_branch) begin
            if (branch_abs) begin
                next_pc = offset_zx;
            end else begin
                next_pc = pc + offset_sx;
            end
        end
    end

    always_comb begin
        state_next = HALTED;
        case (state)
            HALTED: begin
                // run takes priority over a simultaneous step press
                if (run) begin
                    state_next = RUNNING;
                end else if (step_rise) begin
                    state_next = STEPPING;
                end else begin
                    state_next = HALTED;
                end
            end
            RUNNING: begin
                if (halt_req || !run) begin
                    state_next = HALTED;
                end else begin
                    state_next = RUNNING;
                end
            end
            STEPPING: state_next = HALTED;
            default:  state_next = HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= HALTED;
            step_q  <= 1'b0;
            pc      <= PC_WIDTH'(RESET_VECTOR);
            retired <= '0;
        end else begin
            state  <= state_next;
            step_q <= step;
            // The exit cycle (halt_req or run falling) still retires, so the
            // PC moves past that instruction before halting.
            if (commit) begin
                pc      <= next_pc;
                retired <= retired + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        take_branch;
    logic        branch_abs;
    logic [7:0]  branch_offset;
    logic        run;
    logic        step;
    logic        halt_req;
    logic [7:0]  pc;
    logic [7:0]  pc_plus1;
    logic        commit;
    logic        running;
    logic [15:0] retired;

    int n_pass = 0;
    int n_fail = 0;

    // Reference model: "free" = executing continuously, "one_shot" = exactly
    // one instruction is owed because a step press was accepted.
    logic [7:0]  m_pc;
    logic [15:0] m_ret;
    bit          m_free;
    bit          m_one_shot;
    bit          m_prev_step;

    pc_sequencer #(
        .PC_WIDTH(8), .OFFSET_WIDTH(8), .RESET_VECTOR(0), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .take_branch(take_branch), .branch_abs(branch_abs),
        .branch_offset(branch_offset), .run(run), .step(step), .halt_req(halt_req),
        .pc(pc), .pc_plus1(pc_plus1), .commit(commit), .running(running),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] target_of(input logic [7:0] cur, input bit br,
                                             input bit ab, input logic [7:0] off);
        int t;
        if (!br) t = int'(cur) + 1;
        else if (ab) t = int'(off);
        else t = int'(cur) + int'($signed(off));
        t = ((t % 256) + 256) % 256;
        return t[7:0];
    endfunction

    task automatic model_reset();
        m_pc = 8'h00; m_ret = 16'h0; m_free = 0; m_one_shot = 0; m_prev_step = 0;
    endtask

    // Check outputs against the model with the current inputs applied, then
    // advance the model and the DUT through one rising edge.
    task automatic do_cycle();
        bit rise;
        int t;
        #1;
        chk("pc", pc, m_pc);
        t = (int'(m_pc) + 1) % 256;
        chk("pc_plus1", pc_plus1, t[7:0]);
        chk("commit", commit, m_free || m_one_shot);
        chk("running", running, m_free);
        chk("retired", retired, m_ret);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_free || m_one_shot) begin
                m_pc  = target_of(m_pc, take_branch, branch_abs, branch_offset);
                m_ret = m_ret + 16'd1;
            end
            rise = step && !m_prev_step;
            if (m_free) m_free = run && !halt_req;
            else if (m_one_shot) m_one_shot = 0;
            else if (run) m_free = 1;
            else if (rise) m_one_shot = 1;
            m_prev_step = step;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle();
    endtask

    task automatic set_br(input bit br, input bit ab, input logic [7:0] off);
        take_branch = br; branch_abs = ab; branch_offset = off;
    endtask

    initial begin
        rst_n = 0; run = 0; step = 0; halt_req = 0;
        set_br(0, 0, 8'h00);
        @(posedge clk);
        #1;
        model_reset();
        do_cycle();                       // second reset edge, checks reset outputs
        rst_n = 1;
        cycles(10);                       // idle
        chk("idle_pc", pc, 8'h00);

        // Free run, sequential
        run = 1;
        cycles(6);
        chk("free_pc", pc, 8'h05);
        chk("free_retired", retired, 16'd5);

        // Branch forms
        set_br(1, 1, 8'h10); do_cycle();
        chk("abs_pc10", pc, 8'h10);
        set_br(1, 0, 8'hFC); do_cycle();
        chk("rel_minus4", pc, 8'h0C);
        set_br(1, 1, 8'h10); do_cycle();
        set_br(1, 1, 8'h80); do_cycle();
        chk("abs_80", pc, 8'h80);
        set_br(1, 1, 8'hFF); do_cycle();
        set_br(0, 0, 8'h00); do_cycle();
        chk("wrap_00", pc, 8'h00);

        // HALT instruction at 0x07
        set_br(1, 1, 8'h07); do_cycle();
        set_br(0, 0, 8'h00);
        halt_req = 1; do_cycle();
        halt_req = 0; run = 0;
        chk("halt_pc", pc, 8'h08);
        cycles(3);
        chk("halt_commit", commit, 1'b0);
        run = 1; cycles(3);
        chk("resume_pc", pc, 8'h0A);

        // Get to 0x20 on an exit cycle that branches
        set_br(1, 1, 8'h20); run = 0; do_cycle();
        set_br(0, 0, 8'h00);
        cycles(2);
        chk("step_start_pc", pc, 8'h20);
        step = 1; cycles(6);
        chk("step_held_pc", pc, 8'h21);
        step = 0; cycles(2);
        step = 1; cycles(3);
        chk("step_again_pc", pc, 8'h22);
        step = 0;
        run = 1; cycles(2);
        step = 1; cycles(2); step = 0; cycles(2); step = 1; cycles(2); step = 0;

        // Reset mid-run at 0x33
        set_br(1, 1, 8'h33); do_cycle();
        set_br(0, 0, 8'h00);
        chk("pre_reset_pc", pc, 8'h33);
        rst_n = 0; do_cycle();
        rst_n = 1; run = 0;
        chk("mid_reset_pc", pc, 8'h00);
        chk("mid_reset_retired", retired, 16'd0);
        chk("mid_reset_running", running, 1'b0);
        cycles(2);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rst_n       = ($urandom_range(0, 49) != 0);
            run         = ($urandom_range(0, 3) != 0) ? run : ~run;
            step        = $urandom_range(0, 1);
            halt_req    = ($urandom_range(0, 9) == 0);
            take_branch = $urandom_range(0, 1);
            branch_abs  = $urandom_range(0, 1);
            branch_offset = 8'($urandom);
            do_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the branch-decision logic.
- Consumes the registered-per-cycle "take branch" decision and the branch target field.
- Holds the PC and computes the next PC: sequential, relative, or absolute branch.
- Owns the processor run/halt/single-step control and emits the commit qualifier that gates all architectural state writes (register file, flags) in the single-cycle datapath.

Parameters:
- PC_WIDTH, 8, width of the program counter and instruction address.
- OFFSET_WIDTH, 8, width of the branch offset/target field from the instruction.
- RESET_VECTOR, 0, PC value loaded on reset.
- COUNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- take_branch  in  1  branch-taken decision from branch logic for the current instruction.
- branch_abs  in  1  1 = absolute target, 0 = PC-relative offset.
- branch_offset  in  OFFSET_WIDTH  branch field; signed when relative, unsigned when absolute.
- run  in  1  level: 1 requests free-running execution.
- step  in  1  synchronised debounced button; a rising edge requests one instruction.
- halt_req  in  1  decoded HALT instruction at the current PC.
- pc  out  PC_WIDTH  current instruction address (registered).
- pc_plus1  out  PC_WIDTH  pc+1 modulo 2^PC_WIDTH (combinational).
- commit  out  1  current instruction retires this cycle; write-enable qualifier.
- running  out  1  state is RUNNING.
- retired  out  COUNT_WIDTH  count of committed instructions.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Register values: pc=RESET_VECTOR, state=HALTED, step_q=0, retired=0.
  - Resulting outputs: commit=0, running=0.
  - Reset applied mid-run or mid-step aborts immediately; no commit occurs in the reset cycle.
- States: HALTED, RUNNING, STEPPING (2-bit encoding).
  - commit = (state==RUNNING) | (state==STEPPING), decoded from state only.
  - running = (state==RUNNING).
- Step edge detection: step_q <= step every cycle. step_rise = step & ~step_q.
- Transitions, evaluated each edge:
  - HALTED:
    - run=1 -> RUNNING.
    - else step_rise=1 -> STEPPING.
    - else remain HALTED.
    - If run and step_rise are both 1, run wins.
  - RUNNING:
    - halt_req=1 or run=0 -> HALTED.
    - else remain RUNNING.
    - step_rise is ignored.
  - STEPPING: always -> HALTED after exactly one commit cycle; halt_req has no additional effect.
- Next-PC computation (combinational):
  - take_branch=0: next_pc = pc+1.
  - take_branch=1 and branch_abs=0: next_pc = pc + sign_extend(branch_offset).
  - take_branch=1 and branch_abs=1: next_pc = zero_extend(branch_offset).
  - If OFFSET_WIDTH > PC_WIDTH, the upper bits of the offset are truncated.
  - All arithmetic is modulo 2^PC_WIDTH: wrap-around is silent, with no fault.
- PC update:
  - When commit=1: pc <= next_pc, then retired <= retired+1, wrapping at 2^COUNT_WIDTH.
  - When commit=0: pc and retired hold; take_branch, branch_abs and branch_offset are don't-care.
- Exit cycles still retire:
  - The instruction that raises halt_req, or that is executing when run falls, still commits. The PC advances past it, so resuming continues at the following instruction.
  - Branch semantics apply on that exit cycle as well.
- Latency: the new PC is visible one clock after the committing edge. Single-step advances the PC by exactly one instruction per step rising edge.
- Held inputs: a held step=1 produces only one step. A new step requires step to return to 0 for at least one cycle.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, run=0, step=0 -> pc=0x00, commit=0, running=0, retired=0 for 10 cycles.
- Free-run sequential: run=1, take_branch=0 for 5 cycles -> commit=1 from the cycle after run rises; pc steps 0x00..0x05; retired=5.
- Branch forms:
  - pc=0x10, relative offset=0xFC (-4) -> next pc=0x0C.
  - pc=0x10, absolute offset=0x80 -> next pc=0x80.
  - pc=0xFF, no branch -> next pc=0x00 (wrap).
- HALT instruction: running, halt_req=1 at pc=0x07 -> that cycle commits, pc=0x08, state HALTED, commit=0 thereafter; run toggling 0->1 resumes at 0x08.
- Single step: HALTED at pc=0x20, step held high for 6 cycles -> exactly one commit, pc=0x21, retired+1. Release step, press again -> pc=0x22. Step asserted while RUNNING -> no effect.
- Reset mid-run: RUNNING at pc=0x33, rst_n=0 for one edge -> pc=0x00, HALTED, retired=0, with no commit on that edge.
